// File: rtl/iir_deemph_pkg.sv
// Shared types and constants for the first-order de-emphasis IIR filter.
// Coefficients are quantised with BITS_DEFAULT fractional bits.
package iir_deemph_pkg;

  typedef enum logic [1:0] {
    S_READ,
    S_MULT,
    S_SUM,
    S_WRITE
  } state_t;

  localparam int signed   COEF_B0      = 178;
  localparam int signed   COEF_B1      = 178;
  localparam int signed   COEF_A1      = -666;
  localparam int unsigned BITS_DEFAULT = 10;

endpackage

// File: rtl/iir_deemph_if.sv
// Upstream-FIFO read side and downstream-FIFO write side of the filter.
// master is the filter's view, slave is the FIFO/environment view.
interface iir_deemph_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] in_dout;
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] out_din;
  logic                         out_full;
  logic                         out_wr_en;

  modport master (
    input  in_dout,
    input  in_empty,
    input  out_full,
    output in_rd_en,
    output out_din,
    output out_wr_en
  );

  modport slave (
    output in_dout,
    output in_empty,
    output out_full,
    input  in_rd_en,
    input  out_din,
    input  out_wr_en
  );
endinterface

// File: rtl/iir_deemph_dequantize.sv
// Signed division of a full-width product by 2^BITS, truncating toward zero,
// with the result truncated to WIDTH bits.
module dequantize #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 10
) (
  input  logic signed [2*WIDTH-1:0] p_i,
  output logic signed [WIDTH-1:0]   q_o
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] BIAS = PW'((64'd1 << BITS) - 64'd1);

  logic signed [PW-1:0] biased;

  always_comb begin
    // Biasing negatives turns the floor of >>> into truncation toward zero.
    biased = p_i + (p_i[PW-1] ? BIAS : '0);
    q_o    = WIDTH'(biased >>> BITS);
  end
endmodule

// File: rtl/iir_deemph.sv
// De-emphasis filter y[n] = deq(B0*x[n]) + deq(B1*x[n-1]) - deq(A1*y[n-1]),
// one sample per READ/MULT/SUM/WRITE pass between two FIFOs.
module iir_deemph
  import iir_deemph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BITS       = BITS_DEFAULT
) (
  input logic          clock,
  input logic          reset,
  iir_deemph_if.master fifo
);
  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [PW-1:0]         prod_t;

  localparam sample_t B0_W = sample_t'(COEF_B0);
  localparam sample_t B1_W = sample_t'(COEF_B1);
  localparam sample_t A1_W = sample_t'(COEF_A1);

  state_t  state_q, state_d;
  sample_t x0_q, x0_d, x1_q, x1_d, y1_q, y1_d, y_q, y_d;
  prod_t   p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  sample_t d0, d1, d2;

  dequantize #(.WIDTH(DATA_WIDTH), .BITS(BITS)) u_deq0 (.p_i(p0_q), .q_o(d0));
  dequantize #(.WIDTH(DATA_WIDTH), .BITS(BITS)) u_deq1 (.p_i(p1_q), .q_o(d1));
  dequantize #(.WIDTH(DATA_WIDTH), .BITS(BITS)) u_deq2 (.p_i(p2_q), .q_o(d2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      y_q     <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      y_q     <= y_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    x0_d           = x0_q;
    x1_d           = x1_q;
    y1_d           = y1_q;
    y_d            = y_q;
    p0_d           = p0_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    fifo.in_rd_en  = 1'b0;
    fifo.out_wr_en = 1'b0;
    fifo.out_din   = '0;

    case (state_q)
      S_READ: begin
        if (!fifo.in_empty) begin
          fifo.in_rd_en = 1'b1;
          x1_d          = x0_q;
          x0_d          = fifo.in_dout;
          state_d       = S_MULT;
        end
      end
      S_MULT: begin
        p0_d    = prod_t'(x0_q) * prod_t'(B0_W);
        p1_d    = prod_t'(x1_q) * prod_t'(B1_W);
        p2_d    = prod_t'(y1_q) * prod_t'(A1_W);
        state_d = S_SUM;
      end
      S_SUM: begin
        y_d     = d0 + d1 - d2;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!fifo.out_full) begin
          fifo.out_wr_en = 1'b1;
          fifo.out_din   = y_q;
          y1_d           = y_q;
          state_d        = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase

    // Strobes are combinational from state, so hold them low while reset is applied.
    if (reset) begin
      fifo.in_rd_en  = 1'b0;
      fifo.out_wr_en = 1'b0;
      fifo.out_din   = '0;
    end
  end
endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: FIFO-side stimulus, a recurrence model of the filter,
// and one negedge compare process; directed vectors pin the model to literals.
module tb_iir_deemph;
  localparam int unsigned W = 32;

  logic clock;
  logic reset;

  iir_deemph_if #(.DATA_WIDTH(W)) ifc ();

  iir_deemph #(.DATA_WIDTH(W), .BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .fifo  (ifc)
  );

  int checks = 0;
  int errors = 0;

  int     in_q[$];
  int     exp_q[$];
  int     out_log[$];
  int     rd_cnt = 0;
  int     wr_cnt = 0;
  int     cyc = 0;
  int     rd_cyc = 0;
  int     xprev = 0;
  int     yprev = 0;
  int     empty_pct = 0;
  int     full_pct = 0;
  logic   force_full = 1'b0;
  logic   exact_lat = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Real-number view of deq: integer division in SV already truncates toward zero.
  function automatic int deq(longint p);
    return int'(p / 1024);
  endfunction

  function automatic int model_y(int x, int xp, int yp);
    return deq(178 * longint'(x)) + deq(178 * longint'(xp)) - deq(-666 * longint'(yp));
  endfunction

  function automatic longint log_at(int idx);
    if (idx < 0 || idx >= out_log.size()) return -64'sd999999999;
    return longint'(out_log[idx]);
  endfunction

  // FIFO emulation: inputs change only 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    ifc.in_empty = (in_q.size() == 0) || ($urandom_range(99) < empty_pct);
    ifc.in_dout  = (in_q.size() != 0) ? in_q[0] : 0;
    ifc.out_full = force_full || ($urandom_range(99) < full_pct);
  end

  // Compare process.
  always @(negedge clock) begin
    logic rd_now, wr_now;
    int   y;
    cyc++;
    rd_now = ifc.in_rd_en;
    wr_now = ifc.out_wr_en;
    if (reset) begin
      check("reset_rd_en", rd_now, 0);
      check("reset_wr_en", wr_now, 0);
      check("reset_out_din", ifc.out_din, 0);
      exp_q.delete();
      xprev = 0;
      yprev = 0;
    end else begin
      check("rd_wr_exclusive", longint'(rd_now && wr_now), 0);
      if (!wr_now) check("out_din_idle", ifc.out_din, 0);
      if (rd_now) begin
        check("rd_when_not_empty", ifc.in_empty, 0);
        y = model_y(int'(ifc.in_dout), xprev, yprev);
        xprev = int'(ifc.in_dout);
        yprev = y;
        exp_q.push_back(y);
        if (in_q.size() != 0) void'(in_q.pop_front());
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (wr_now) begin
        check("wr_when_not_full", ifc.out_full, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got %0d expected no write", ifc.out_din);
        end else begin
          check("out_din", ifc.out_din, exp_q.pop_front());
        end
        if (exact_lat) check("latency", cyc - rd_cyc, 3);
        out_log.push_back(int'(ifc.out_din));
        wr_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    in_q.delete();
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", in_q.size() + exp_q.size());
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int base, rdc, wrc, n, v;
    reset        = 1'b1;
    ifc.in_dout  = '0;
    ifc.in_empty = 1'b1;
    ifc.out_full = 1'b0;

    // Impulse response.
    do_reset();
    exact_lat = 1'b1;
    base = out_log.size();
    in_q.push_back(1024);
    in_q.push_back(0);
    in_q.push_back(0);
    wait_idle(200);
    check("impulse_y0", log_at(base), 178);
    check("impulse_y1", log_at(base + 1), 293);
    check("impulse_y2", log_at(base + 2), 190);

    // Starvation keeps history intact.
    rdc = rd_cnt;
    repeat (20) @(posedge clock);
    check("starve_no_rd", rd_cnt - rdc, 0);
    in_q.push_back(0);
    wait_idle(200);
    check("starve_resume", log_at(base + 3), 123);

    // Negative truncation.
    do_reset();
    base = out_log.size();
    in_q.push_back(-1);
    wait_idle(200);
    check("neg_minus1", log_at(base), 0);
    do_reset();
    base = out_log.size();
    in_q.push_back(-2048);
    wait_idle(200);
    check("neg_minus2048", log_at(base), -356);

    // Backpressure.
    do_reset();
    exact_lat  = 1'b0;
    force_full = 1'b1;
    rdc  = rd_cnt;
    wrc  = wr_cnt;
    base = out_log.size();
    in_q.push_back(1024);
    in_q.push_back(1024);
    repeat (20) @(posedge clock);
    check("bp_reads", rd_cnt - rdc, 1);
    check("bp_writes", wr_cnt - wrc, 0);
    force_full = 1'b0;
    repeat (3) @(posedge clock);
    check("bp_release_writes", wr_cnt - wrc, 1);
    check("bp_held_value", log_at(base), 178);
    wait_idle(200);
    check("bp_second_value", log_at(base + 1), 471);

    // Reset in the middle of a sample.
    do_reset();
    exact_lat = 1'b1;
    wrc = wr_cnt;
    rdc = rd_cnt;
    in_q.push_back(500);
    n = 0;
    while (rd_cnt == rdc && n < 50) begin
      @(posedge clock);
      n++;
    end
    check("mid_reset_read_seen", rd_cnt - rdc, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    in_q.push_back(7);
    repeat (3) @(posedge clock);
    in_q.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    base = out_log.size();
    in_q.push_back(1024);
    wait_idle(200);
    check("mid_reset_first", log_at(base), 178);
    check("mid_reset_writes", wr_cnt - wrc, 1);

    // Random stream with random empty/full patterns.
    do_reset();
    exact_lat = 1'b0;
    empty_pct = 30;
    full_pct  = 30;
    wrc = wr_cnt;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(3))
        0:       v = int'($urandom());
        1:       v = int'($urandom_range(10000)) - 5000;
        2:       v = ($urandom_range(1) == 0) ? 32'sh7fffffff : 32'sh80000000;
        default: v = int'($urandom_range(1 << 20)) - (1 << 19);
      endcase
      in_q.push_back(v);
    end
    wait_idle(30000);
    check("stream_count", wr_cnt - wrc, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_deemph.md
IIR_DEEMPH -- requirements
Module: iir_deemph

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the sample width (signed two's complement) on both FIFO sides.
REQ-002 The block SHALL have parameter BITS, default 10, meaning the coefficient fractional bits used for dequantisation.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_dout, input, DATA_WIDTH, the head word of the upstream FIFO (one channel of the left/right splitter output).
REQ-006 The block SHALL have port in_empty, input, 1, high when the upstream FIFO is empty.
REQ-007 The block SHALL have port in_rd_en, output, 1, a one-cycle pop of the upstream FIFO.
REQ-008 The block SHALL have port out_din, output, DATA_WIDTH, the filtered sample to the downstream FIFO.
REQ-009 The block SHALL have port out_full, input, 1, high when the downstream FIFO is full.
REQ-010 The block SHALL have port out_wr_en, output, 1, a one-cycle push to the downstream FIFO.

Function
REQ-011 The block SHALL compute y[n] = deq(B0*x[n]) + deq(B1*x[n-1]) - deq(A1*y[n-1]), with B0 = 178, B1 = 178 and A1 = -666 (32-bit 0xFFFFFD66).
REQ-012 deq(p) SHALL be signed division of p by 2^BITS, truncating toward zero: for negative p, add 2^BITS-1 before the arithmetic shift.
REQ-013 Products SHALL be full 2*DATA_WIDTH signed; each deq result is truncated to DATA_WIDTH and the sum wraps modulo 2^DATA_WIDTH with no saturation.
REQ-014 The FSM SHALL have states S_READ, S_MULT, S_SUM and S_WRITE.
REQ-015 S_READ: while in_empty=1, the FSM SHALL hold with in_rd_en=0.
REQ-016 S_READ: when in_empty=0, the FSM SHALL assert in_rd_en for exactly one cycle, load x1<=x0 and x0<=in_dout, then go to S_MULT.
REQ-017 S_MULT SHALL register p0=B0*x0, p1=B1*x1 and p2=A1*y1, then go to S_SUM.
REQ-018 S_SUM SHALL register y = deq(p0)+deq(p1)-deq(p2), then go to S_WRITE.
REQ-019 S_WRITE: while out_full=1, the FSM SHALL hold with out_wr_en=0 and y unchanged.
REQ-020 S_WRITE: when out_full=0, the block SHALL drive out_din=y with out_wr_en=1 for one cycle, load y1<=y, then go to S_READ.
REQ-021 Latency SHALL be 3 cycles from the in_rd_en cycle to the out_wr_en cycle when out_full=0; throughput SHALL be at most one sample per 4 cycles.
REQ-022 in_rd_en and out_wr_en SHALL never be high in the same cycle, and neither SHALL be high outside its state.
REQ-023 out_din SHALL be 0 in every cycle where out_wr_en=0.
REQ-024 An unreachable state encoding SHALL return to S_READ on the next cycle.

Reset
REQ-025 On reset assertion the block SHALL immediately set state=S_READ, x0=x1=y1=y=p0=p1=p2=0, in_rd_en=0, out_wr_en=0 and out_din=0, including when reset arrives mid-sample.
REQ-026 After reset release the block SHALL not pop the upstream FIFO before the first rising edge.

Structure
REQ-027 A shared package SHALL hold the state_t enum, the B0/B1/A1 coefficient constants and the BITS default.
REQ-028 A sub-module named dequantize (combinational, parameterised by width and BITS) SHALL implement deq() and be instantiated three times.

Verification
REQ-029 Impulse: after reset, feed 1024 then 0, 0 -> outputs 178, 293 (178 + 115), then 190 (0 - deq(-666*293) = 190).
REQ-030 Negative truncation: after reset, feed -1 -> output 0; feed -2048 after reset -> output -356.
REQ-031 Backpressure: hold out_full=1 for 10 cycles while in S_WRITE -> no out_wr_en and no in_rd_en; on release, exactly one write of the held y.
REQ-032 Starvation: in_empty=1 for 20 cycles -> in_rd_en=0 throughout and history registers unchanged.
REQ-033 Reset mid-sample: assert reset in S_SUM, release, then feed 1024 -> first output is 178 (history cleared).
REQ-034 Stream: 1000 random samples with random empty/full patterns -> output sequence matches the C reference model bit-exactly with no lost or duplicated samples.
